// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array edge feeder.
package sa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } feeder_state_t;

    localparam int ELEM_BITS_DEF = 8;

    // LSB position of a lane inside a packed lane vector
    function automatic int lane_lsb(input int lane, input int elem_bits);
        return lane * elem_bits;
    endfunction

endpackage

// File: rtl/sa_delay_line.sv
// DEPTH-stage register chain, cleared on reset, advancing only when en is high.
module sa_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else if (en) begin
            r_stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign q = r_stage[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Edge feeder for the INT8 systolic array: skews one vector per K-step across
// the lanes and sequences clear / shift-enable / flush / done for each tile.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start; skew stages hold zero
//   S_CLEAR  | one cycle, pe_clr asserted
//   S_STREAM | s_ready high, one vector accepted per handshake
//   S_FLUSH  | N_LANES cycles draining the skew pipeline, no new data
//   S_DONE   | one cycle, done asserted
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int N_LANES   = 4,
    parameter int ELEM_BITS = ELEM_BITS_DEF,
    parameter int K_BITS    = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [K_BITS-1:0]            k_len,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [N_LANES*ELEM_BITS-1:0] s_data,
    output logic [N_LANES*ELEM_BITS-1:0] lane_data,
    output logic [N_LANES-1:0]           lane_v,
    output logic                         pe_clr,
    output logic                         pe_shift_en,
    output logic                         busy,
    output logic                         done
);

    localparam int FC_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(N_LANES - 1);

    feeder_state_t     r_state;
    feeder_state_t     w_state_nxt;
    logic [K_BITS-1:0] r_k_len_q;
    logic [K_BITS-1:0] r_kcnt;
    logic [K_BITS-1:0] w_k_last;
    logic [FC_W-1:0]   r_fcnt;
    logic              w_hs;

    assign w_hs     = s_valid && (r_state == S_STREAM);
    assign w_k_last = r_k_len_q - K_BITS'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_CLEAR;
            S_CLEAR:  w_state_nxt = (r_k_len_q != '0) ? S_STREAM : S_DONE;
            S_STREAM: if (w_hs && (r_kcnt == w_k_last)) w_state_nxt = S_FLUSH;
            S_FLUSH:  if (r_fcnt == FC_LAST) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready     = 1'b0;
        pe_clr      = 1'b0;
        pe_shift_en = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE:   busy = 1'b0;
            S_CLEAR:  pe_clr = 1'b1;
            S_STREAM: begin
                s_ready     = 1'b1;
                pe_shift_en = 1'b1;
            end
            S_FLUSH:  pe_shift_en = 1'b1;
            S_DONE:   done = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    // kcnt is compared before increment, so k_len = 2^K_BITS-1 never wraps
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_k_len_q <= '0;
            r_kcnt    <= '0;
            r_fcnt    <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_k_len_q <= k_len;
                r_kcnt    <= '0;
            end else if (w_hs) begin
                r_kcnt <= r_kcnt + K_BITS'(1);
            end
            if (r_state == S_FLUSH) begin
                r_fcnt <= r_fcnt + FC_W'(1);
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // Non-handshake cycles inject an all-zero bubble so lane alignment holds
    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic [ELEM_BITS:0] w_d;
        logic [ELEM_BITS:0] w_q;

        assign w_d = w_hs ? {1'b1, s_data[lane_lsb(i, ELEM_BITS) +: ELEM_BITS]} : '0;

        sa_delay_line #(
            .DEPTH (i + 1),
            .WIDTH (ELEM_BITS + 1)
        ) u_dl (
            .clk  (clk),
            .rstn (rstn),
            .en   (busy),
            .d    (w_d),
            .q    (w_q)
        );

        assign lane_v[i] = w_q[ELEM_BITS];
        assign lane_data[lane_lsb(i, ELEM_BITS) +: ELEM_BITS] = w_q[ELEM_BITS-1:0];
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder: tile timeline and skewed lane events are
// predicted from the stimulus schedule and compared by a negedge monitor.
module tb_sa_skew_feeder;

    localparam int N  = 4;
    localparam int E  = 8;
    localparam int KB = 5;

    localparam logic [4:0] C_CLEAR  = 5'b01010; // {s_ready,pe_clr,shift,busy,done}
    localparam logic [4:0] C_STREAM = 5'b10110;
    localparam logic [4:0] C_FLUSH  = 5'b00110;
    localparam logic [4:0] C_DONE   = 5'b00011;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic [KB-1:0]  k_len = '0;
    logic           s_valid = 1'b0;
    logic [N*E-1:0] s_data = '0;
    logic           s_ready;
    logic [N*E-1:0] lane_data;
    logic [N-1:0]   lane_v;
    logic           pe_clr;
    logic           pe_shift_en;
    logic           busy;
    logic           done;

    sa_skew_feeder #(
        .N_LANES   (N),
        .ELEM_BITS (E),
        .K_BITS    (KB)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .k_len       (k_len),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .lane_data   (lane_data),
        .lane_v      (lane_v),
        .pe_clr      (pe_clr),
        .pe_shift_en (pe_shift_en),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           c;
        logic [E-1:0] d;
    } ev_t;

    ev_t            lq [N][$];
    logic [4:0]     exp_ctrl [int];
    logic [N*E-1:0] vec_q [$];
    int             gap_q [$];
    int             checks = 0;
    int             failures = 0;
    bit             mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [4:0] e;
        ev_t        ev;
        if (mon_en && rstn) begin
            e = exp_ctrl.exists(cyc) ? exp_ctrl[cyc] : 5'b0;
            chk("ctrl", 32'({s_ready, pe_clr, pe_shift_en, busy, done}), 32'(e));
            for (int i = 0; i < N; i++) begin
                if (lane_v[i]) begin
                    if (lq[i].size() == 0) begin
                        chk("lane_v_unexpected", 32'(lane_v[i]), 32'd0);
                    end else begin
                        ev = lq[i].pop_front();
                        chk("lane_cycle", 32'(cyc), 32'(ev.c));
                        chk("lane_data", 32'(lane_data[i*E +: E]), 32'(ev.d));
                    end
                end else begin
                    chk("lane_data_bubble_zero", 32'(lane_data[i*E +: E]), 32'd0);
                end
            end
        end
    end

    task automatic do_abort();
        rstn = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("abort_outputs", 32'({lane_v, busy, s_ready, pe_shift_en, pe_clr, done}), 32'd0);
        chk("abort_lane_data", 32'(lane_data), 32'd0);
        for (int i = 0; i < N; i++) lq[i].delete();
        exp_ctrl.delete();
        vec_q.delete();
        gap_q.delete();
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
    endtask

    // Timeline from the start cycle c0: CLEAR at c0+1, STREAM from c0+2,
    // N FLUSH cycles after the last handshake, then one DONE cycle.
    task automatic run_tile(input int k, input bit hold, input bit retry, input int abort_at);
        int             c0;
        int             c;
        int             g;
        logic [N*E-1:0] v;
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b1;
        k_len = KB'(k);
        @(posedge clk); #1;
        start = 1'b0;
        k_len = KB'($urandom);
        exp_ctrl[c0+1] = C_CLEAR;
        @(posedge clk); #1;
        c = c0 + 2;
        if (k == 0) begin
            exp_ctrl[c] = C_DONE;
            @(posedge clk); #1;
            return;
        end
        for (int j = 0; j < k; j++) begin
            g = (gap_q.size() != 0) ? gap_q.pop_front() : 0;
            v = (vec_q.size() != 0) ? vec_q.pop_front() : N*E'($urandom);
            for (int b = 0; b <= g; b++) begin
                if (abort_at >= 0 && (c - (c0 + 2)) == abort_at) begin
                    do_abort();
                    return;
                end
                exp_ctrl[c] = C_STREAM;
                if (b == g) begin
                    s_valid = 1'b1;
                    s_data = v;
                    for (int i = 0; i < N; i++) lq[i].push_back('{c: c + 1 + i, d: v[i*E +: E]});
                end else begin
                    s_valid = 1'b0;
                    s_data = N*E'($urandom);
                end
                @(posedge clk); #1;
                c++;
            end
        end
        for (int f = 0; f < N; f++) exp_ctrl[c+f] = C_FLUSH;
        exp_ctrl[c+N] = C_DONE;
        s_valid = hold;
        s_data = N*E'($urandom);
        if (retry) begin
            start = 1'b1;
            k_len = KB'($urandom_range(1, 7));
        end
        repeat (N + 1) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'({s_ready, pe_clr, pe_shift_en, busy, done}), 32'd0);
        chk("reset_lane_v", 32'(lane_v), 32'd0);
        chk("reset_lane_data", 32'(lane_data), 32'd0);
        #3 rstn = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(posedge clk);

        // basic tile
        vec_q = '{32'h04030201, 32'hFCFDFEFF};
        gap_q = '{0, 0};
        run_tile(2, 1'b0, 1'b0, -1);

        // bubbles between vectors
        vec_q = '{N*E'($urandom), N*E'($urandom)};
        gap_q = '{0, 2};
        run_tile(2, 1'b0, 1'b0, -1);

        // zero length
        run_tile(0, 1'b0, 1'b0, -1);

        // valid held high past the last vector, restart attempt during FLUSH
        gap_q = '{0, 0, 0};
        run_tile(3, 1'b1, 1'b1, -1);
        repeat (3) @(posedge clk);

        // reset in the second STREAM cycle, then a clean single-vector tile
        gap_q = '{0, 0, 0, 0, 0};
        run_tile(5, 1'b0, 1'b0, 1);
        run_tile(1, 1'b0, 1'b0, -1);

        for (int t = 0; t < 8; t++) begin
            int k;
            k = int'($urandom_range(0, 6));
            for (int j = 0; j < k; j++) begin
                vec_q.push_back(N*E'($urandom));
                gap_q.push_back(int'($urandom_range(0, 2)));
            end
            run_tile(k, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), -1);
        end

        // full-scale k_len without counter wrap
        run_tile(2**KB - 1, 1'b0, 1'b0, -1);

        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) chk("lane_queue_drained", 32'(lq[i].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
